// File: rtl/wb_sram_target_pkg.sv
// Shared Wishbone definitions for the SRAM target.
// Contents:
//   - CTI cycle-type encodings (classic, constant, incrementing, end-of-burst).
//   - BTE burst-type encodings (linear, wrap-4, wrap-8, wrap-16).
//   - wb_state_e : target state machine encoding.
//   - bte_wrap_mask() : low-index-bit mask that a wrapping burst increments.
package wb_sram_target_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } wb_state_e;

    // Bits of the word index that advance during a wrapping burst; the
    // remaining upper bits stay fixed. Linear bursts return an empty mask.
    function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 4'h3;
            BTE_WRAP8:  return 4'h7;
            BTE_WRAP16: return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle.
// Parameters: ADDR_WIDTH (byte address), DATA_WIDTH (multiple of 8).
// Modports:
//   slave  : inputs ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE; outputs DAT_R, ACK, ERR
//   master : the mirror image
//
// Handshake: a beat is requested while CYC & STB are high; it completes in
// the cycle where the target raises ACK (or ERR). Request fields must stay
// stable until that cycle. Dropping CYC abandons the whole cycle.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADR;
    logic [2:0]              CTI;
    logic [1:0]              BTE;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic                    CYC;
    logic                    STB;
    logic                    WE;
    logic                    ACK;
    logic                    ERR;

    modport slave (
        input  ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
        output DAT_R, ACK, ERR
    );

    modport master (
        output ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
        input  DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_sram_target_mem.sv
// Word-organised storage for wb_sram_target.
// One storage array on one clock with synchronous read and per-byte write
// enables. The write and read addresses are separate so that a burst can
// commit the current beat while prefetching the next word in the same cycle.
// Ports:
//   clk   : clock
//   we    : per-byte write enables for word waddr
//   waddr : write word index
//   wdata : write data
//   re    : read enable; rdata holds its value while re is low
//   raddr : read word index
//   rdata : registered read data (old contents on a same-cycle write)
module wb_sram_target_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int WORDS      = 1024,
    localparam int ADDR_W     = $clog2(WORDS),
    localparam int BYTES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic [BYTES-1:0]      we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wb_sram_target.sv
// Wishbone B4 SRAM target with classic and incrementing-burst support.
// Parameters:
//   WB_ADDR_WIDTH : byte-address width
//   WB_DATA_WIDTH : data width, multiple of 8
//   MEM_WORDS     : storage depth in words, power of two
//   MEM_BASE      : byte address of word 0
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rstn  : synchronous active-low reset (memory contents are kept)
//   s     : Wishbone target port
//   state : current state machine state (observation only)
//
// A request seen in IDLE captures the word index and starts the memory read,
// so the response comes one cycle later in RESP. While an incrementing burst
// keeps being acked, the next index is prefetched in the acking cycle, giving
// one beat per cycle.
module wb_sram_target
    import wb_sram_target_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_WORDS     = 1024,
    parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE      = '0
) (
    input  logic      clk,
    input  logic      rstn,
    wb_if.slave       s,
    output wb_state_e state
);

    localparam int BYTES = WB_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [WB_ADDR_WIDTH-1:0] DEPTH = WB_ADDR_WIDTH'(MEM_WORDS);

    wb_state_e              state_n;
    logic [IDX_W-1:0]       idx_q, idx_n;
    logic                   range_q, range_n;
    logic                   rd_en;
    logic [IDX_W-1:0]       rd_addr;
    logic [BYTES-1:0]       wr_be;
    logic [WB_DATA_WIDTH-1:0] mem_q;

    logic                   req;
    logic                   ack;
    logic                   err;

    // Decode of the address presented with a new request.
    logic [WB_ADDR_WIDTH-1:0] req_off;
    logic [WB_ADDR_WIDTH-1:0] req_word;
    logic [IDX_W-1:0]         req_idx;
    logic                     req_in_range;

    assign req_off      = s.ADR - MEM_BASE;
    assign req_word     = req_off >> SHIFT;
    assign req_idx      = req_word[IDX_W-1:0];
    assign req_in_range = (s.ADR >= MEM_BASE) && (req_word < DEPTH);

    // Next burst index. The extra top bit of idx_inc is the linear carry out
    // of the last word; it turns the next beat into an error rather than
    // letting the index wrap to word 0.
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] wrap_mask;
    logic [IDX_W-1:0] adv_idx;
    logic             adv_in_range;

    assign idx_inc      = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign wrap_mask    = IDX_W'(bte_wrap_mask(s.BTE));
    assign adv_idx      = (s.BTE == BTE_LINEAR)
                        ? idx_inc[IDX_W-1:0]
                        : ((idx_q & ~wrap_mask) | (idx_inc[IDX_W-1:0] & wrap_mask));
    assign adv_in_range = (s.BTE == BTE_LINEAR) ? ~idx_inc[IDX_W] : 1'b1;

    // Responses depend only on state and the registered range flag, so
    // ACK and ERR are mutually exclusive by construction.
    assign req   = s.CYC & s.STB;
    assign ack   = (state == ST_RESP) & req &  range_q;
    assign err   = (state == ST_RESP) & req & ~range_q;
    assign s.ACK = ack;
    assign s.ERR = err;

    // Out-of-range beats (and the post-reset state) present zero data.
    assign s.DAT_R = range_q ? mem_q : '0;

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        range_n = range_q;
        rd_en   = 1'b0;
        rd_addr = idx_q;
        wr_be   = '0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_n = ST_RESP;
                    idx_n   = req_idx;
                    range_n = req_in_range;
                    rd_en   = 1'b1;
                    rd_addr = req_idx;
                end
            end
            ST_RESP: begin
                if (!s.CYC) begin
                    state_n = ST_IDLE;
                end else if (s.STB) begin
                    if (ack && s.WE) begin
                        wr_be = s.SEL;
                    end
                    if (ack && (s.CTI == CTI_INCR)) begin
                        idx_n   = adv_idx;
                        range_n = adv_in_range;
                        rd_en   = 1'b1;
                        rd_addr = adv_idx;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            range_q <= 1'b0;
        end else begin
            state   <= state_n;
            idx_q   <= idx_n;
            range_q <= range_n;
        end
    end

    wb_sram_target_mem #(
        .DATA_WIDTH (WB_DATA_WIDTH),
        .WORDS      (MEM_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_be),
        .waddr (idx_q),
        .wdata (s.DAT_W),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (mem_q)
    );

endmodule
